// File: rtl/freq_ctrl_pkg.sv
// freq_ctrl_pkg: shared states, widths and gate-scale table for freq_gate_ctrl
package freq_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, GATE, SETTLE, LATCH} state_t;
  localparam int DEF_DIGITS = 6;
  localparam int DATA_W = 4 * DEF_DIGITS;
  localparam int GATE_SCALE_MAX = 1000;
  function automatic int gate_scale(input logic [1:0] sel);
    return sel == 2'd0 ? 1 : sel == 2'd1 ? 10 : sel == 2'd2 ? 100 : GATE_SCALE_MAX;
  endfunction
  function automatic int max3(input int a, input int b, input int c);
    return a > b ? (a > c ? a : c) : (b > c ? b : c);
  endfunction
endpackage

// File: rtl/freq_gate_ctrl_gate_timer.sv
// gate_timer: loadable down-counter that stops at zero with a registered done flag
module gate_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] value,
  output logic         done
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (rst) begin
      cnt  <= '0;
      done <= 1'b0;
    end else if (load) begin
      cnt  <= value;
      done <= value == '0;
    end else if (en && cnt != '0) begin
      cnt  <= cnt - 1'b1;
      done <= cnt == W'(1);
    end
endmodule

// File: rtl/freq_gate_ctrl.sv
// freq_gate_ctrl: clear/gate/settle sequencer and result latch for a cascaded BCD frequency counter
// FCTL_GATE_SEL_EN adds gate_sel[1:0] scaling the gate by 1/10/100/1000
module freq_gate_ctrl
  import freq_ctrl_pkg::*;
#(
  parameter int GATE_CYCLES   = 1000,
  parameter int CLR_CYCLES    = 2,
  parameter int SETTLE_CYCLES = 2,
  parameter int DIGITS        = DEF_DIGITS
) (
  input  logic                clk,
  input  logic                clr,
`ifdef FCTL_GATE_SEL_EN
  input  logic [1:0]          gate_sel,
`endif
  input  logic                start,
  input  logic                cont,
  input  logic [4*DIGITS-1:0] bcd_in,
  input  logic                ovf_in,
  input  logic                rd_ack,
  output logic                cnt_clr,
  output logic                cnt_ena,
  output logic                busy,
  output logic [4*DIGITS-1:0] result,
  output logic                result_valid,
  output logic                overflow,
  output logic                overrun
);
`ifdef FCTL_GATE_SEL_EN
  localparam int GATE_MAX = GATE_CYCLES * GATE_SCALE_MAX;
`else
  localparam int GATE_MAX = GATE_CYCLES;
`endif
  localparam int TW = $clog2(max3(CLR_CYCLES, GATE_MAX, SETTLE_CYCLES)) + 1;
  state_t state, state_next;
  logic load, done, sticky;
  logic [TW-1:0] load_val, gate_len;
`ifdef FCTL_GATE_SEL_EN
  logic [1:0] sel_q;
  always_ff @(posedge clk)
    if (clr) sel_q <= '0;
    else if (state_next == CLEAR && state != CLEAR) sel_q <= gate_sel;
  assign gate_len = TW'(GATE_CYCLES * gate_scale(sel_q) - 1);
`else
  assign gate_len = TW'(GATE_CYCLES - 1);
`endif
  // The single timer is reloaded on every state change with that state's length minus one.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = (start || cont) ? CLEAR : IDLE;
      CLEAR:   state_next = done ? GATE : CLEAR;
      GATE:    state_next = done ? SETTLE : GATE;
      SETTLE:  state_next = done ? LATCH : SETTLE;
      LATCH:   state_next = cont ? CLEAR : IDLE;
      default: state_next = IDLE;
    endcase
    load = state_next != state;
    load_val = state_next == CLEAR  ? TW'(CLR_CYCLES - 1) :
               state_next == GATE   ? gate_len :
               state_next == SETTLE ? TW'(SETTLE_CYCLES - 1) : '0;
  end
  gate_timer #(.W(TW)) u_timer (
    .clk   (clk),
    .rst   (clr),
    .load  (load),
    .en    (state != IDLE),
    .value (load_val),
    .done  (done)
  );
  // Outputs follow the next state so they line up with the state they describe.
  always_ff @(posedge clk)
    if (clr) begin
      state        <= IDLE;
      cnt_clr      <= 1'b0;
      cnt_ena      <= 1'b0;
      busy         <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      overflow     <= 1'b0;
      overrun      <= 1'b0;
      sticky       <= 1'b0;
    end else begin
      state   <= state_next;
      cnt_clr <= state_next == CLEAR;
      cnt_ena <= state_next == GATE;
      busy    <= state_next != IDLE;
      sticky  <= (state_next == CLEAR && state != CLEAR) ? 1'b0 : sticky | (state == GATE && ovf_in);
      if (state == LATCH) begin
        result       <= bcd_in;
        overflow     <= sticky;
        result_valid <= 1'b1;
        overrun      <= result_valid & ~rd_ack;
      end else if (rd_ack && result_valid) begin
        result_valid <= 1'b0;
        overrun      <= 1'b0;
      end
    end
endmodule
